// File: rtl/beep_driver.sv
// Beep driver: turns a single-cycle start pulse into a burst of square-wave beeps on the buzzer pin.
// Optional BEEP_REPEAT_EN: bursts repeat, separated by repeat_gap silent cycles, until stop or reset.
module beep_driver #(
  parameter int unsigned tone_half_period = 25000,
  parameter int unsigned beep_on          = 5000000,
  parameter int unsigned beep_off         = 5000000,
  parameter int unsigned beep_count       = 3,
  parameter int unsigned repeat_gap       = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  output logic buzzer,
  output logic busy,
  output logic done
);

  localparam int unsigned ON_OFF_MAX = (beep_on > beep_off) ? beep_on : beep_off;
`ifdef BEEP_REPEAT_EN
  localparam int unsigned PHASE_MAX  = (ON_OFF_MAX > repeat_gap) ? ON_OFF_MAX : repeat_gap;
`else
  localparam int unsigned PHASE_MAX  = ON_OFF_MAX;
`endif
  localparam int unsigned PW = $clog2(PHASE_MAX + 1);
  localparam int unsigned TW = $clog2(tone_half_period + 1);
  localparam int unsigned IW = $clog2(beep_count + 1);

  localparam logic [PW-1:0] ON_LAST  = PW'(beep_on - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(beep_off - 1);
  localparam logic [TW-1:0] TONE_LAST = TW'(tone_half_period - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(beep_count - 1);
`ifdef BEEP_REPEAT_EN
  localparam logic [PW-1:0] GAP_LAST = PW'(repeat_gap - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] phase, phase_d;
  logic [TW-1:0] tone, tone_d;
  logic [IW-1:0] idx, idx_d;
  logic          buzzer_d, busy_d, done_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      phase  <= '0;
      tone   <= '0;
      idx    <= '0;
      buzzer <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      phase  <= phase_d;
      tone   <= tone_d;
      idx    <= idx_d;
      buzzer <= buzzer_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  // Next state and next outputs; stop overrides everything outside IDLE
  always_comb begin
    state_d  = state;
    phase_d  = phase;
    tone_d   = tone;
    idx_d    = idx;
    buzzer_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    if (state != IDLE && stop) begin
      state_d = IDLE;
      phase_d = '0;
      tone_d  = '0;
      idx_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state_d  = ON;
            phase_d  = '0;
            tone_d   = '0;
            idx_d    = '0;
            buzzer_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
        ON: begin
          busy_d   = 1'b1;
          buzzer_d = buzzer;
          if (phase == ON_LAST) begin
            phase_d  = '0;
            tone_d   = '0;
            buzzer_d = 1'b0;
            if (idx == IDX_LAST) begin
              done_d = 1'b1;
`ifdef BEEP_REPEAT_EN
              state_d = GAP;
`else
              state_d = IDLE;
              busy_d  = 1'b0;
              idx_d   = '0;
`endif
            end else begin
              state_d = OFF;
              idx_d   = idx + IW'(1);
            end
          end else begin
            phase_d = phase + PW'(1);
            if (tone == TONE_LAST) begin
              tone_d   = '0;
              buzzer_d = ~buzzer;
            end else begin
              tone_d = tone + TW'(1);
            end
          end
        end
        OFF: begin
          busy_d = 1'b1;
          if (phase == OFF_LAST) begin
            state_d  = ON;
            phase_d  = '0;
            tone_d   = '0;
            buzzer_d = 1'b1;
          end else begin
            phase_d = phase + PW'(1);
          end
        end
`ifdef BEEP_REPEAT_EN
        GAP: begin
          busy_d = 1'b1;
          if (phase == GAP_LAST) begin
            state_d  = ON;
            phase_d  = '0;
            tone_d   = '0;
            idx_d    = '0;
            buzzer_d = 1'b1;
          end else begin
            phase_d = phase + PW'(1);
          end
        end
`endif
        default: begin
          state_d = IDLE;
          phase_d = '0;
          tone_d  = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/beep_driver.md
Name: beep_driver

Overview:
- Output-side counterpart of the switch debouncer.
- Debouncer: noisy physical input → clean level/edge pulses. This block: clean single-cycle event pulses → timed physical output.
- On a start pulse (typically a debouncer rise pulse or the timer-expired pulse), drives the piezo buzzer pin with a square-wave tone gated into a fixed burst of beeps.
- Sits between the egg-timer control logic and the buzzer pad.

Parameters:
- tone_half_period, default 25000: clk cycles per tone half-period; buzzer toggles at this rate while a beep is on. Must be ≥1.
- beep_on, default 5000000: clk cycles per beep on-phase. Must be ≥1.
- beep_off, default 5000000: clk cycles of silence between beeps. Must be ≥1.
- beep_count, default 3: number of beeps per burst. Must be ≥1.
- repeat_gap, default 50000000: silence cycles between bursts. Used only with BEEP_REPEAT_EN.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a burst.
- stop  input  1  single-cycle request to silence immediately.
- buzzer  output  1  tone output to piezo pad; registered.
- busy  output  1  high while a burst is in progress; registered.
- done  output  1  one-cycle pulse when a burst completes normally; registered.

Behaviour:
- One clock domain, clk. rst_n is synchronous, active-low: sampled only on posedge clk.
- Reset (rst_n=0 at a posedge): next cycle state=IDLE, buzzer=0, busy=0, done=0, all counters 0. Applies mid-burst as well.
- Counter widths: $clog2 of (limit+1) for each parameter.

State machine: IDLE, ON, OFF (plus GAP only with BEEP_REPEAT_EN).
- IDLE:
  - start=1 and stop=0 → ON next cycle; beep index=0, phase counter=0, tone counter=0.
  - Outputs in IDLE: buzzer=0, busy=0.
- ON:
  - Lasts exactly beep_on cycles.
  - busy=1.
  - buzzer=1 on the first ON cycle, then toggles every tone_half_period cycles. tone_half_period=1 gives a toggle every cycle.
  - Tone phase restarts at the start of every ON phase.
  - After beep_on cycles:
    - If beep index < beep_count-1 → OFF, and the index increments.
    - Otherwise → IDLE, with done=1 for that one cycle and busy=0 in the same cycle.
- OFF:
  - Lasts exactly beep_off cycles.
  - buzzer=0, busy=1.
  - Then → ON.
- Latency: start sampled at cycle T gives buzzer=1 and busy=1 at T+1. No trailing OFF after the last beep.
- Burst length: beep_count*beep_on + (beep_count-1)*beep_off cycles.

Boundary and priority rules:
- stop=1 in any non-IDLE state → IDLE next cycle: buzzer=0, busy=0, done=0, no done pulse.
- start while busy: ignored. The burst is not restarted or extended.
- start and stop in the same cycle: stop wins; the block stays or goes IDLE.
- stop in IDLE: no effect.
- done is never high for more than one cycle, and never high while busy=1 (except in repeat mode, see below).

Optional Feature:
- Macro: BEEP_REPEAT_EN.
- Defined:
  - After the last ON of a burst, go to GAP (buzzer=0, busy=1) for repeat_gap cycles, then back to ON with beep index=0.
  - done pulses one cycle at the first GAP cycle of each burst; busy stays 1.
  - Only stop or reset exits the loop.
  - stop during GAP → IDLE next cycle.
- Undefined: no GAP state, repeat_gap unused, single-burst behaviour as above.

Test Plan:
- All tests use tone_half_period=2, beep_on=8, beep_off=4, beep_count=3, repeat_gap=6.
- Reset: hold rst_n=0 for 3 cycles with start=1 → buzzer=0, busy=0, done=0 throughout, and the block stays IDLE one cycle after release with start=0.
- Full burst: start pulse at T → buzzer 1,1,0,0,1,1,0,0 over T+1..T+8; buzzer=0 over T+9..T+12; buzzer pattern repeats over T+13..T+20; buzzer=0 over T+21..T+24; pattern again over T+25..T+32; busy=1 over T+1..T+32; done=1 only at T+33, with busy=0 at T+33.
- Stop mid-beep: start at T, stop at T+5 → buzzer=0 and busy=0 from T+6; done never asserts. Start at T+10 → new burst, buzzer=1 at T+11.
- Ignored start and priority: start at T, start again at T+15 → done still at exactly T+33. Start and stop together in IDLE → busy stays 0.
- Reset mid-operation: rst_n=0 at T+14 (inside the second ON phase) → at T+15 buzzer=0, busy=0, done=0.
- BEEP_REPEAT_EN: start at T → first burst identical to the full-burst case; done=1 at T+33 with busy=1; buzzer=0 over T+33..T+38; buzzer=1 at T+39 starting the next burst; stop at T+40 → busy=0 at T+41.
